// File: rtl/response_tx_sm.sv
// Response frame transmitter: sends RSN, RC, RDC header words, then RDC data words, onto a valid/ready stream.
// Define RSP_TIMEOUT_EN to replace stalled data with 32'h0BAD_DA7A padding words after 256 idle cycles.
module response_tx_sm (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        send_rsp,
    input  logic [31:0] rsp_ser_num,
    input  logic [31:0] rsp_code,
    input  logic [7:0]  rsp_data_cnt,
    input  logic [31:0] dat_tdata,
    input  logic        dat_tvalid,
    output logic        dat_tready,
    output logic [31:0] tx_tdata,
    output logic        tx_tvalid,
    output logic [0:3]  tx_tkeep,
    output logic        tx_tlast,
    input  logic        tx_tready,
    output logic        rsp_done,
    output logic        rsp_timeout,
    output logic        sm_idle
);
    // state     | meaning
    // IDLE      | waiting for send_rsp
    // SEND_RSN  | presenting latched serial number
    // SEND_RC   | presenting latched response code
    // SEND_RDC  | presenting data count (tlast when zero)
    // SEND_DATA | passing data words through, or padding
    // DONE      | one-cycle completion pulse
    typedef enum logic [5:0] {
        IDLE      = 6'b000001,
        SEND_RSN  = 6'b000010,
        SEND_RC   = 6'b000100,
        SEND_RDC  = 6'b001000,
        SEND_DATA = 6'b010000,
        DONE      = 6'b100000
    } state_t;

    localparam logic [31:0] PAD_WORD = 32'h0BAD_DA7A;

    state_t      r_state;
    logic [31:0] r_rsn;
    logic [31:0] r_rc;
    logic [7:0]  r_rdc;
    logic [7:0]  r_cnt;

    logic        w_pad;
    logic        w_data_accept;
    logic [31:0] w_tx_tdata;
    logic        w_tx_tvalid;
    logic        w_tx_tlast;
    logic        w_dat_tready;

`ifdef RSP_TIMEOUT_EN
    logic [7:0]  r_stall;
    logic        r_pad;
    logic        r_timeout;

    assign w_pad       = r_pad;
    assign rsp_timeout = r_timeout;

    // Stall timer reloads on every valid data cycle; reaching zero with no data flips to padding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall   <= 8'hFF;
            r_pad     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == IDLE && send_rsp) begin
                r_timeout <= 1'b0;
            end
            if (r_state != SEND_DATA) begin
                r_stall <= 8'hFF;
                r_pad   <= 1'b0;
            end else if (!r_pad) begin
                if (dat_tvalid) begin
                    r_stall <= 8'hFF;
                end else if (r_stall == 8'd0) begin
                    r_pad     <= 1'b1;
                    r_timeout <= 1'b1;
                end else begin
                    r_stall <= r_stall - 8'd1;
                end
            end
        end
    end
`else
    assign w_pad       = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign w_data_accept = tx_tready & (w_pad | dat_tvalid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_rsn   <= '0;
            r_rc    <= '0;
            r_rdc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (send_rsp) begin
                        r_rsn   <= rsp_ser_num;
                        r_rc    <= rsp_code;
                        r_rdc   <= rsp_data_cnt;
                        r_cnt   <= rsp_data_cnt;
                        r_state <= SEND_RSN;
                    end
                end
                SEND_RSN: begin
                    if (tx_tready) r_state <= SEND_RC;
                end
                SEND_RC: begin
                    if (tx_tready) r_state <= SEND_RDC;
                end
                SEND_RDC: begin
                    if (tx_tready) r_state <= (r_rdc == 8'd0) ? DONE : SEND_DATA;
                end
                SEND_DATA: begin
                    if (w_data_accept) begin
                        r_cnt <= r_cnt - 8'd1;
                        if (r_cnt == 8'd1) r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Header words come from the latches; data words pass straight through from the source.
    always_comb begin
        w_tx_tdata   = '0;
        w_tx_tvalid  = 1'b0;
        w_tx_tlast   = 1'b0;
        w_dat_tready = 1'b0;
        case (r_state)
            SEND_RSN: begin
                w_tx_tdata  = r_rsn;
                w_tx_tvalid = 1'b1;
            end
            SEND_RC: begin
                w_tx_tdata  = r_rc;
                w_tx_tvalid = 1'b1;
            end
            SEND_RDC: begin
                w_tx_tdata  = {24'b0, r_rdc};
                w_tx_tvalid = 1'b1;
                w_tx_tlast  = (r_rdc == 8'd0);
            end
            SEND_DATA: begin
                w_tx_tlast = (r_cnt == 8'd1);
                if (w_pad) begin
                    w_tx_tdata  = PAD_WORD;
                    w_tx_tvalid = 1'b1;
                end else begin
                    w_tx_tdata   = dat_tdata;
                    w_tx_tvalid  = dat_tvalid;
                    w_dat_tready = tx_tready;
                end
            end
            default: begin
            end
        endcase
    end

    assign tx_tdata   = w_tx_tdata;
    assign tx_tvalid  = w_tx_tvalid;
    assign tx_tlast   = w_tx_tlast;
    assign tx_tkeep   = w_tx_tvalid ? 4'b1111 : 4'b0000;
    assign dat_tready = w_dat_tready;
    assign rsp_done   = (r_state == DONE);
    assign sm_idle    = (r_state == IDLE);

endmodule
